// File: rtl/branch_target_buffer.sv
// Tagged branch target buffer: combinational lookup, next-cycle training with
// 2-bit saturating direction counters, and a sequential invalidate sweep.
module branch_target_buffer #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IDX_W = 10,
  parameter int unsigned TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic [PC_W-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            inv_req,
  output logic            inv_busy
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic [1:0]       upd_ctr;
  logic             upd_hit;
  logic             ctr_we, tgt_we, tag_we, set_valid;
  logic [1:0]       ctr_wdata;
  logic             unused_upd;

  // Bit 0 and the bits above the tag do not address the table.
  assign unused_upd = ^upd_pc;

  assign lk_idx  = lookup_pc[IDX_W:1];
  assign lk_tag  = lookup_pc[IDX_W+TAG_W:IDX_W+1];
  assign upd_idx = upd_pc[IDX_W:1];
  assign upd_tag = upd_pc[IDX_W+TAG_W:IDX_W+1];
  assign upd_ctr = ctr_q[upd_idx];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign inv_busy = (state_q == SWEEP);

  // Lookup: pre-update contents, forced miss while the sweep runs.
  always_comb begin
    pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !inv_busy;
    pred_taken = pred_hit && ctr_q[lk_idx][1];
    pred_pc    = pred_taken ? tgt_q[lk_idx] : lookup_pc + PC_W'(2);
  end

  // Training decode: saturating counter moves on hits, allocation on taken misses.
  always_comb begin
    ctr_we    = 1'b0;
    tgt_we    = 1'b0;
    tag_we    = 1'b0;
    set_valid = 1'b0;
    ctr_wdata = upd_ctr;
    if (upd_valid && !inv_busy) begin
      if (upd_hit) begin
        ctr_we = 1'b1;
        if (upd_taken) begin
          tgt_we = 1'b1;
          if (upd_ctr != 2'd3) ctr_wdata = upd_ctr + 2'd1;
        end else if (upd_ctr != 2'd0) begin
          ctr_wdata = upd_ctr - 2'd1;
        end
      end else if (upd_taken) begin
        set_valid = 1'b1;
        tag_we    = 1'b1;
        ctr_we    = 1'b1;
        ctr_wdata = 2'd2;
        tgt_we    = 1'b1;
      end
    end
  end

  // Sweep FSM next state: restart on every inv_req, leave after the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (inv_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (inv_req) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep FSM state and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Valid bits: sweep clears one per cycle; training never overlaps a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inv_busy) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (set_valid) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Entry payload storage; qualified by valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[upd_idx] <= upd_tag;
    if (ctr_we) ctr_q[upd_idx] <= ctr_wdata;
    if (tgt_we) tgt_q[upd_idx] <= upd_target;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a table-level model.
module tb_branch_target_buffer;

  localparam int ENT = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lookup_pc = '0;
  logic [15:0] pred_pc;
  logic        pred_hit, pred_taken;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = '0;
  logic        inv_req = 1'b0;
  logic        inv_busy;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model state: one record per table slot, plus remaining busy cycles.
  bit          m_valid [ENT];
  int          m_tag   [ENT];
  int          m_ctr   [ENT];
  logic [15:0] m_tgt   [ENT];
  int          m_rem;

  branch_target_buffer dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .pred_pc(pred_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .inv_req(inv_req), .inv_busy(inv_busy)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(logic [15:0] pc);
    return (int'(pc) >> 1) % ENT;
  endfunction

  function automatic int tag_of(logic [15:0] pc);
    return (int'(pc) >> 11) & 31;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
    m_rem = 0;
  end

  // Model update at each edge, using the rules of the table directly.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
      m_rem = 0;
    end else begin
      if (m_rem == 0 && upd_valid) begin
        int ix;
        bit h;
        ix = idx_of(upd_pc);
        h  = m_valid[ix] && m_tag[ix] == tag_of(upd_pc);
        if (h && upd_taken) begin
          m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
          m_tgt[ix] = upd_target;
        end else if (h) begin
          m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
        end else if (upd_taken) begin
          m_valid[ix] = 1'b1;
          m_tag[ix]   = tag_of(upd_pc);
          m_ctr[ix]   = 2;
          m_tgt[ix]   = upd_target;
        end
      end
      // Every entry is invalid once the sweep ends and misses are forced
      // meanwhile, so clearing the whole table up front is equivalent.
      if (inv_req) begin
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
        m_rem = ENT;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      int ix;
      bit eh, et;
      logic [15:0] ep;
      ix = idx_of(lookup_pc);
      eh = (m_rem == 0) && m_valid[ix] && m_tag[ix] == tag_of(lookup_pc);
      et = eh && m_ctr[ix] >= 2;
      ep = et ? m_tgt[ix] : lookup_pc + 16'd2;
      chk("cmp_hit", 32'(pred_hit), 32'(eh));
      chk("cmp_taken", 32'(pred_taken), 32'(et));
      chk("cmp_pc", 32'(pred_pc), 32'(ep));
      chk("cmp_busy", 32'(inv_busy), 32'(m_rem > 0));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    inv_req   = 1'b0;
  endtask

  task automatic upd(logic [15:0] pc, logic tk, logic [15:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    nxt();
  endtask

  task automatic look(string nm, logic [15:0] pc, logic eh, logic et, logic [15:0] ep);
    lookup_pc = pc;
    @(negedge clk);
    chk({nm, "_hit"}, 32'(pred_hit), 32'(eh));
    chk({nm, "_taken"}, 32'(pred_taken), 32'(et));
    chk({nm, "_pc"}, 32'(pred_pc), 32'(ep));
    nxt();
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    started = 1'b1;

    look("reset", 16'h0040, 1'b0, 1'b0, 16'h0042);
    chk("reset_busy", 32'(inv_busy), 32'd0);

    // Update cycle still shows the old contents; next cycle sees the new entry.
    lookup_pc = 16'h0040;
    upd_valid = 1'b1; upd_pc = 16'h0040; upd_taken = 1'b1; upd_target = 16'h0100;
    @(negedge clk);
    chk("nobypass_pc", 32'(pred_pc), 32'h0042);
    nxt();
    look("alloc", 16'h0040, 1'b1, 1'b1, 16'h0100);
    look("alias", 16'h0840, 1'b0, 1'b0, 16'h0842);

    upd(16'h0040, 1'b0, 16'h0000);
    look("ctr1", 16'h0040, 1'b1, 1'b0, 16'h0042);
    upd(16'h0040, 1'b1, 16'h0100);
    upd(16'h0040, 1'b1, 16'h0100);
    upd(16'h0040, 1'b0, 16'h0000);
    look("ctr2", 16'h0040, 1'b1, 1'b1, 16'h0100);
    upd(16'h0840, 1'b1, 16'h0200);
    look("evict", 16'h0040, 1'b0, 1'b0, 16'h0042);
    look("evictor", 16'h0840, 1'b1, 1'b1, 16'h0200);

    upd(16'hFFFE, 1'b1, 16'h1234);
    upd(16'hFFFE, 1'b0, 16'h0000);
    upd(16'hFFFE, 1'b0, 16'h0000);
    look("wrap", 16'hFFFE, 1'b1, 1'b0, 16'h0000);

    // Random traffic over a small index/tag window so hits and aliases recur.
    for (int i = 0; i < 400; i++) begin
      lookup_pc = 16'((($urandom_range(0, 3)) << 11) | (($urandom_range(0, 7)) << 1) | $urandom_range(0, 1));
      upd_valid  = ($urandom_range(0, 2) != 0);
      upd_pc     = 16'((($urandom_range(0, 3)) << 11) | (($urandom_range(0, 7)) << 1) | $urandom_range(0, 1));
      upd_taken  = 1'($urandom_range(0, 1));
      upd_target = 16'($urandom);
      nxt();
    end

    // Sweep with an update accepted in the inv_req cycle, a dropped update,
    // and a restart on the 500th busy cycle.
    upd_valid = 1'b1; upd_pc = 16'h0100; upd_taken = 1'b1; upd_target = 16'h0300;
    inv_req   = 1'b1;
    lookup_pc = 16'h0840;
    nxt();
    n = 0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (!inv_busy) break;
      n++;
      #1;
      if (n == 5) begin
        upd_valid = 1'b1; upd_pc = 16'h0040; upd_taken = 1'b1; upd_target = 16'h0500;
      end
      if (n == 500) inv_req = 1'b1;
      nxt();
    end
    chk("sweep_len", 32'(n), 32'd1524);
    look("post_a", 16'h0840, 1'b0, 1'b0, 16'h0842);
    look("post_b", 16'hFFFE, 1'b0, 1'b0, 16'h0000);
    look("post_c", 16'h0100, 1'b0, 1'b0, 16'h0102);
    look("post_d", 16'h0040, 1'b0, 1'b0, 16'h0042);

    // Reset in the middle of a sweep.
    upd(16'h0040, 1'b1, 16'h0700);
    inv_req = 1'b1;
    nxt();
    repeat (9) nxt();
    chk("mid_busy", 32'(inv_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(inv_busy), 32'd0);
    nxt();
    rst_n = 1'b1;
    look("after_rst", 16'h0040, 1'b0, 1'b0, 16'h0042);
    chk("after_rst_busy", 32'(inv_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised, tagged branch target buffer with 2-bit saturating direction counters; replaces the core's untagged 1024-entry predictor table.
- Lookup is combinational from the fetch PC so the core can use the next-PC prediction in the same cycle.
- Write-back trains the table one cycle later.
- Supports a sequential invalidate sweep, used when self-modifying code or a context change makes stored targets stale.

Parameters:
- PC_W, 16, PC width in bits; instructions are 2-byte aligned, so bit 0 is ignored.
- IDX_W, 10, index width; ENTRIES = 2**IDX_W. Index = pc[IDX_W:1].
- TAG_W, 5, tag width. Tag = pc[IDX_W+TAG_W:IDX_W+1]. Requires IDX_W+TAG_W <= PC_W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_pc  in  PC_W  fetch PC.
- pred_pc  out  PC_W  predicted next PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit and counter >= 2.
- upd_valid  in  1  train request this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  branch was taken.
- upd_target  in  PC_W  resolved target; used only when upd_taken=1.
- inv_req  in  1  single-cycle pulse that starts the invalidate sweep.
- inv_busy  out  1  sweep in progress.

Behaviour:
- Entry contents: valid, tag[TAG_W], ctr[2], target[PC_W].
- Reset (async, rst_n=0):
  - All valid bits = 0; FSM = IDLE; sweep pointer = 0; inv_busy = 0.
  - Targets, tags and counters need no reset.
  - Outputs during and after reset: pred_hit=0, pred_taken=0, pred_pc=lookup_pc+2.
- Lookup (combinational):
  - hit = valid[idx] & tag[idx]==tag(lookup_pc) & !inv_busy.
  - pred_pc = pred_taken ? target[idx] : lookup_pc+2, truncated to PC_W (0xFFFE wraps to 0x0000 at PC_W=16).
- Update (posedge, only when upd_valid & !inv_busy):
  - Hit and taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit and not taken: ctr = max(ctr-1, 0). The entry stays valid; target is unchanged.
  - Miss and taken: allocate and overwrite any aliasing entry. valid=1, tag=tag(upd_pc), ctr=2, target=upd_target.
  - Miss and not taken: no change.
  - Hit for update purposes uses valid and tag only, not inv_busy.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents (no bypass). The new value is visible from the next cycle.
- Invalidate FSM:
  - States: IDLE and SWEEP.
  - IDLE -> SWEEP on inv_req; pointer <= 0; inv_busy=1 from the next cycle.
  - In SWEEP, each cycle clears valid[pointer] and increments pointer. After clearing entry ENTRIES-1, go to IDLE.
  - inv_busy is high for exactly ENTRIES cycles.
  - inv_req during SWEEP restarts the sweep: pointer <= 0, and the sweep lasts ENTRIES cycles from that point.
  - While inv_busy=1: lookups report a miss (pred_pc=lookup_pc+2) and updates are dropped.
  - In the same cycle as an inv_req accepted from IDLE, an upd_valid is still applied; the sweep then clears it.
- Reset asserted mid-sweep: FSM returns to IDLE immediately and all entries become invalid.
- upd_pc and lookup_pc bit 0 is ignored for index and tag.

Test Plan (defaults; upd_* pulses are one cycle):
- Reset, then lookup_pc=0x0040 -> pred_pc=0x0042, pred_hit=0, pred_taken=0, inv_busy=0.
- upd pc=0x0040 taken target=0x0100; next cycle lookup 0x0040 -> pred_pc=0x0100, hit=1, taken=1. In the update cycle itself the lookup still shows 0x0042.
- Alias: after the previous step, lookup 0x0840 (same index, tag 1 vs 0) -> hit=0, pred_pc=0x0842.
- Training and aliasing:
  - From ctr=2 on 0x0040, not-taken -> hit=1, taken=0, pred_pc=0x0042.
  - Then taken twice -> ctr=3; then not-taken once -> still predicts 0x0100.
  - Taken to 0x0840 with target 0x0200 evicts the 0x0040 entry; lookup 0x0040 -> miss.
- Wrap: allocate 0xFFFE, then not-taken twice; lookup 0xFFFE -> hit=1, taken=0, pred_pc=0x0000.
- Invalidate with valid entries present:
  - Pulse inv_req -> inv_busy=1 for 1024 cycles; lookups during the sweep miss; an upd at cycle 5 is ignored.
  - Re-pulse inv_req at cycle 500 -> busy extends to cycle 500+1024.
  - Afterwards all lookups miss.
  - rst_n low at cycle 10 of a sweep -> inv_busy=0 immediately.
